// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and entry type for the fetch front end
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    // addi x0, x0, 0
    localparam logic [InstBus-1:0] NopInst = 32'h0000_0013;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic Stop        = 1'b1;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous prefetch FIFO of {pc, inst} entries
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push_i / wdata_i   enqueue an entry (ignored when full without a pop)
//   pop_i              dequeue the head entry (ignored when empty)
//   flush_i            drop every entry; wins over push and pop
//   rdata_o            head entry, combinational from storage
//   count_o            number of stored entries, 0..DEPTH
//   full_o / empty_o   occupancy flags
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RV32I instruction fetch: PC, ROM interface, prefetch FIFO, decode handshake
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall_i                          freeze PC and fetches; the FIFO keeps draining
//   branch_flag_i, branch_target_i   redirect pulse and byte target; flushes the FIFO
//   rom_ce_o, rom_addr_o             ROM enable and byte address (always the PC)
//   rom_inst_i                       combinational ROM data for rom_addr_o
//   id_ready_i                       decode accepts the head entry
//   if_valid_o, if_pc_o, if_inst_o   head entry towards decode
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [InstBus-1:0]     NOP_INST   = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_inst_i,
    input  logic                   id_ready_i,
    output logic                   if_valid_o,
    output logic [InstAddrBus-1:0] if_pc_o,
    output logic [InstBus-1:0]     if_inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   rom_ce_q;
    logic                   push;
    logic                   pop;
    fetch_entry_t           wr_entry;
    fetch_entry_t           head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rom_ce_o   = rom_ce_q;
    assign rom_addr_o = pc_q;

    assign if_valid_o = (fifo_count != '0);
    assign if_pc_o    = fifo_empty ? '0 : head.pc;
    assign if_inst_o  = fifo_empty ? NOP_INST : head.inst;

    assign pop  = if_valid_o & id_ready_i;
    // A full FIFO still takes a new word when decode drains the head this cycle.
    assign push = (rom_ce_q == ChipEnable) & (stall_i != Stop) & (branch_flag_i != Branch)
                & (~fifo_full | pop);

    assign wr_entry = '{pc: pc_q, inst: rom_inst_i};

    always_comb begin
        pc_d = pc_q;
        if (branch_flag_i == Branch) begin
            pc_d = word_align(branch_target_i);
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q     <= RESET_PC;
            rom_ce_q <= ChipDisable;
        end else begin
            pc_q     <= pc_d;
            rom_ce_q <= ChipEnable;
        end
    end

    // A branch flushes; any pop in that cycle is discarded along with the entries.
    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop & ~branch_flag_i),
        .flush_i (branch_flag_i),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : NOP;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_ready_i      (id_ready_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of fetched words, a PC and a ROM-enable flag.
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_ce = 1'b0;
    bit          started = 0;

    always @(posedge clk) begin
        int  n;
        bit  do_pop;
        bit  do_push;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc = 32'h0;
            m_ce = 1'b0;
            started = 1;
        end else if (started) begin
            n      = mq.size();
            do_pop = (n != 0) && id_ready_i;
            if (branch_flag_i) begin
                mq.delete();
                m_pc = branch_target_i & 32'hFFFF_FFFC;
            end else begin
                do_push = m_ce && !stall_i && ((n < DEPTH) || do_pop);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc   = m_pc;
                    e.inst = rom_word(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_ce = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_valid", {31'b0, if_valid_o}, {31'b0, mq.size() != 0});
            check("cyc_pc", if_pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
            check("cyc_inst", if_inst_o, (mq.size() != 0) ? mq[0].inst : NOP);
            check("cyc_ce", {31'b0, rom_ce_o}, {31'b0, m_ce});
            check("cyc_addr", rom_addr_o, m_pc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = 32'h0; id_ready_i = 1'b1;
        tick(2);
        check("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_inst", if_inst_o, NOP);
        check("rst_ce", {31'b0, rom_ce_o}, 32'd0);
        check("rst_addr", rom_addr_o, 32'h0);

        // Sequential fetch with decode always ready
        rst = 1'b0;
        #1 check("first_ce_low", {31'b0, rom_ce_o}, 32'd0);
        tick(1);
        check("ce_high", {31'b0, rom_ce_o}, 32'd1);
        check("no_valid_yet", {31'b0, if_valid_o}, 32'd0);
        tick(1);
        check("seq_pc0", if_pc_o, 32'h0);
        check("seq_inst0", if_inst_o, 32'h1000_0000);
        tick(1);
        check("seq_pc1", if_pc_o, 32'h4);
        check("seq_inst1", if_inst_o, 32'h1000_0001);
        tick(1);
        check("seq_pc2", if_pc_o, 32'h8);
        check("seq_addr", rom_addr_o, 32'hC);

        // Decode not ready: two pushes fill the FIFO, then PC holds
        rst = 1'b1; id_ready_i = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(5);
        check("full_addr", rom_addr_o, 32'h8);
        check("full_pc", if_pc_o, 32'h0);
        id_ready_i = 1'b1;
        tick(1);
        check("drain_pc4", if_pc_o, 32'h4);
        tick(1);
        check("drain_pc8", if_pc_o, 32'h8);

        // Branch while full, with decode ready (pop discarded)
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0102;
        tick(1);
        branch_flag_i = 1'b0;
        check("br_valid", {31'b0, if_valid_o}, 32'd0);
        check("br_addr", rom_addr_o, 32'h100);
        tick(1);
        check("br_pc", if_pc_o, 32'h100);
        check("br_inst", if_inst_o, 32'h1000_0040);

        // Fill, then stall with decode ready: FIFO drains, PC frozen
        id_ready_i = 1'b0;
        tick(1);
        stall_i = 1'b1; id_ready_i = 1'b1;
        tick(1);
        check("stall_pc", if_pc_o, 32'h104);
        tick(1);
        check("stall_empty", {31'b0, if_valid_o}, 32'd0);
        tick(1);
        check("stall_addr", rom_addr_o, 32'h108);
        stall_i = 1'b0;
        tick(1);
        check("resume_pc0", if_pc_o, 32'h108);
        tick(1);
        check("resume_pc1", if_pc_o, 32'h10C);

        // Branch and stall together
        branch_flag_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h40;
        tick(1);
        branch_flag_i = 1'b0;
        tick(2);
        check("bs_addr", rom_addr_o, 32'h40);
        check("bs_valid", {31'b0, if_valid_o}, 32'd0);
        stall_i = 1'b0;
        tick(1);
        check("bs_pc", if_pc_o, 32'h40);
        check("bs_inst", if_inst_o, 32'h1000_0010);

        // PC wrap at the top of the address space
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick(1);
        branch_flag_i = 1'b0;
        tick(1);
        check("wrap_addr", rom_addr_o, 32'h0);
        check("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
        check("wrap_inst", if_inst_o, 32'h4FFF_FFFF);
        tick(1);
        check("wrap_next", if_pc_o, 32'h0);

        // Reset mid-stream with a full FIFO
        id_ready_i = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check("mrst_valid", {31'b0, if_valid_o}, 32'd0);
        check("mrst_addr", rom_addr_o, 32'h0);
        check("mrst_ce", {31'b0, rom_ce_o}, 32'd0);
        check("mrst_inst", if_inst_o, NOP);
        rst = 1'b0; id_ready_i = 1'b1;
        tick(2);
        check("mrst_pc", if_pc_o, 32'h0);

        // Mixed directed pattern, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            id_ready_i      = (i % 3) != 0;
            stall_i         = (i % 5) == 2;
            branch_flag_i   = (i % 11) == 7;
            branch_target_i = 32'h200 + i * 8 + (i & 3);
            tick(1);
        end
        branch_flag_i = 1'b0; stall_i = 1'b0; id_ready_i = 1'b1;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end for the RV32I pipeline. It sits between the ctrl/ex branch outputs and the instruction ROM on the fetch side, and if_id on the decode side.
- Owns the PC and drives the ROM chip-enable and byte address.
- Captures each returned instruction with its PC in a small prefetch FIFO.
- Hands entries to if_id with a valid/ready handshake. Handles stalls and branch redirects with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, prefetch entries (power of two, 2..8).
- NOP_INST, 32'h0000_0013, instruction presented when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  ctrl stall for IF; blocks new fetches.
- branch_flag_i  in  1  redirect request, one-cycle pulse.
- branch_target_i  in  32  redirect byte address.
- rom_ce_o  out  1  ROM chip enable (ROM outputs NOP when 0).
- rom_addr_o  out  32  ROM byte address, always equal to pc.
- rom_inst_i  in  32  combinational ROM data for rom_addr_o, already byte-reordered.
- id_ready_i  in  1  if_id accepts the head entry this cycle.
- if_valid_o  out  1  head entry valid.
- if_pc_o  out  32  PC of head entry.
- if_inst_o  out  32  instruction of head entry; NOP_INST when not valid.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst); all registers update only on rising clk.
- Reset values:
  - pc = RESET_PC, rom_ce_o = 0, FIFO count = 0, read/write pointers = 0.
  - if_valid_o = 0, if_pc_o = 0, if_inst_o = NOP_INST.
- After reset:
  - rom_ce_o rises on the first clock edge with rst=0 and stays 1.
  - First fetch happens in the cycle after that edge (one-cycle start latency, matching ROM ce semantics).
- Definitions:
  - pop = if_valid_o & id_ready_i.
  - push = rom_ce_o & ~stall_i & ~branch_flag_i & (count < FIFO_DEPTH | pop).
- On push:
  - Write {pc, rom_inst_i} at the write pointer.
  - pc <= pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- On pop: advance the read pointer.
- Count update: count += push - pop. Simultaneous push and pop when full is legal; count stays at FIFO_DEPTH.
- Head outputs are combinational from the FIFO head register. Fetch-to-decode latency is 1 cycle: an instruction pushed at edge N is visible at if_valid_o after edge N.
- Branch (branch_flag_i = 1), highest priority:
  - Flush the FIFO (count = 0, pointers reset) and set pc <= {branch_target_i[31:2], 2'b00}.
  - No push in that cycle. A pop in that cycle is ignored; the entry is discarded.
  - if_valid_o = 0 on the next cycle; first target fetch occurs on that next cycle.
- Stall (stall_i = 1, no branch):
  - pc and pushes are frozen.
  - Pops continue, so the FIFO can drain.
  - rom_addr_o holds its value.
- Branch and stall in the same cycle: the branch wins. pc is redirected and the FIFO flushed; the stall then holds the new pc.
- Full FIFO with id_ready_i = 0: no push, pc holds; rom_addr_o stays on the next unfetched address.
- rst during any operation discards all entries and restores the reset values on that edge.
- rom_ce_o = 0 never enqueues.

Decomposition:
- Shared defs file:
  - InstAddrBus / InstBus widths.
  - NopInst constant.
  - RstEnable / ChipEnable / ChipDisable.
  - Branch / Stop constants.
- One sub-module: if_fifo. It is a parametrised synchronous FIFO of {pc, inst} with push, pop, flush, count, full and empty. It is instantiated once.
- PC logic and push/pop arbitration stay in if_fetch.

Test Plan:
- Reset release, id_ready_i = 1 permanently, ROM word i = 0x1000_0000 + i:
  - rom_ce_o = 0 in the first cycle after reset.
  - Then if_pc_o = 0, 4, 8… on consecutive cycles, with if_inst_o = 0x1000_0000, 0x1000_0001…
- id_ready_i = 0 for 5 cycles:
  - Exactly 2 pushes, then rom_addr_o holds at 0x8.
  - if_pc_o holds at 0x0.
  - On ready: 0x0, 0x4, 0x8 with no gap or duplicate.
- branch_flag_i pulse with target 0x0000_0102 while the FIFO is full:
  - Next cycle if_valid_o = 0 and rom_addr_o = 0x100.
  - The cycle after, if_pc_o = 0x100; no stale entry ever appears.
- stall_i high for 3 cycles with id_ready_i = 1:
  - The FIFO drains (if_valid_o drops after 2 pops) and pc is unchanged.
  - After release, sequential PCs resume without a skip.
- Branch and stall asserted together with target 0x40:
  - pc = 0x40 while the stall holds.
  - After release, the first output is if_pc_o = 0x40.
- pc at 0xFFFF_FFFC:
  - After push, rom_addr_o = 0x0.
  - rst asserted mid-stream empties the FIFO and returns pc to RESET_PC.
